// File: rtl/alocador_nos_ativos.sv
// -----------------------------------------------------------------------------
// alocador_nos_ativos
//
// Allocator for the pool of NUM_NA active-node (NA) slots in the path-search
// datapath. Each accepted request is looked up against the addresses held by
// active slots (hit). On an ATUALIZAR miss, the lowest free slot is allocated.
// A DESATIVAR releases the slot that holds the address. Free slots come from a
// reservation bitmap combined with the slots' active flags, so no
// initialisation sweep is needed after reset.
//
// Optional feature: define GA_TIMEOUT_EN to bound the wait for a free slot
// to TIMEOUT_CICLOS cycles. When the bound is reached the response reports a
// miss with no target.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid_i/ready_o  upstream handshake (ready only while idle)
//   req_op_i             01 = ATUALIZAR, 10 = DESATIVAR, others are dropped
//   req_*_i              request payload (address, predecessor, cost, distance)
//   na_endereco_i        flat slot addresses, slot i at [ADDR_WIDTH*i +: ADDR_WIDTH]
//   na_ativo_i           slot active flags
//   rsp_valid_o          one-cycle response pulse
//   rsp_habilitar_o      one-hot target slot (zero outside the pulse or on miss)
//   rsp_op_o             echoed op
//   rsp_miss_o           DESATIVAR miss or wait timeout
//   rsp_erro_o           more than one slot hit (the lowest one is used)
//   rsp_*_o              payload latched at acceptance
//   livres_o, cheio_o    registered free-slot count and pool-full flag
// -----------------------------------------------------------------------------
module alocador_nos_ativos #(
  parameter int NUM_NA          = 8,
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int CUSTO_WIDTH     = 4,
  parameter int TIMEOUT_CICLOS  = 16,
  parameter int CNT_WIDTH       = $clog2(NUM_NA + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [1:0]                   req_op_i,
  input  logic [ADDR_WIDTH-1:0]        req_endereco_i,
  input  logic [ADDR_WIDTH-1:0]        req_anterior_i,
  input  logic [CUSTO_WIDTH-1:0]       req_custo_i,
  input  logic [DISTANCIA_WIDTH-1:0]   req_distancia_i,
  input  logic [ADDR_WIDTH*NUM_NA-1:0] na_endereco_i,
  input  logic [NUM_NA-1:0]            na_ativo_i,
  output logic                         rsp_valid_o,
  output logic [NUM_NA-1:0]            rsp_habilitar_o,
  output logic [1:0]                   rsp_op_o,
  output logic                         rsp_miss_o,
  output logic                         rsp_erro_o,
  output logic [ADDR_WIDTH-1:0]        rsp_endereco_o,
  output logic [ADDR_WIDTH-1:0]        rsp_anterior_o,
  output logic [CUSTO_WIDTH-1:0]       rsp_custo_o,
  output logic [DISTANCIA_WIDTH-1:0]   rsp_distancia_o,
  output logic [CNT_WIDTH-1:0]         livres_o,
  output logic                         cheio_o
);

  if (NUM_NA < 2 || NUM_NA > 64 || TIMEOUT_CICLOS < 1) begin : g_bad_params
    $error("alocador_nos_ativos: NUM_NA must be 2..64 and TIMEOUT_CICLOS >= 1");
  end

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSCA  = 2'd1;
  localparam logic [1:0] ST_ESPERA = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [1:0] OP_ATUALIZAR = 2'b01;
  localparam logic [1:0] OP_DESATIVAR = 2'b10;

  logic [1:0]                 state_q,     state_d;
  logic [NUM_NA-1:0]          reservado_q, reservado_d;
  logic [1:0]                 op_q,        op_d;
  logic [ADDR_WIDTH-1:0]      endereco_q,  endereco_d;
  logic [ADDR_WIDTH-1:0]      anterior_q,  anterior_d;
  logic [CUSTO_WIDTH-1:0]     custo_q,     custo_d;
  logic [DISTANCIA_WIDTH-1:0] distancia_q, distancia_d;
  logic [NUM_NA-1:0]          alvo_q,      alvo_d;
  logic                       miss_q,      miss_d;
  logic                       erro_q,      erro_d;
  logic [CNT_WIDTH-1:0]       livres_q,    livres_d;
  logic                       cheio_q,     cheio_d;

  logic [NUM_NA-1:0] hit, hit_oh, livre, livre_oh;
  logic              hit_any, hit_multi, livre_any;

`ifdef GA_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CICLOS + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // Lookup and free-slot search, both with lowest-index priority. A slot whose
  // active flag falls in the current cycle is already free here.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise an always_comb path that skips it infers a latch.
    hit       = '0;
    hit_oh    = '0;
    hit_any   = 1'b0;
    hit_multi = 1'b0;
    livre     = ~na_ativo_i & ~reservado_q;
    livre_oh  = '0;
    livre_any = 1'b0;
    livres_d  = '0;
    for (int i = 0; i < NUM_NA; i++) begin
      hit[i] = na_ativo_i[i] && (na_endereco_i[ADDR_WIDTH*i +: ADDR_WIDTH] == endereco_q);
      if (hit[i]) begin
        if (hit_any) hit_multi = 1'b1;
        else         hit_oh[i] = 1'b1;
        hit_any = 1'b1;
      end
      if (livre[i] && !livre_any) begin
        livre_oh[i] = 1'b1;
        livre_any   = 1'b1;
      end
      livres_d = livres_d + CNT_WIDTH'(livre[i]);
    end
    cheio_d = !livre_any;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    endereco_d  = endereco_q;
    anterior_d  = anterior_q;
    custo_d     = custo_q;
    distancia_d = distancia_q;
    alvo_d      = alvo_q;
    miss_d      = miss_q;
    erro_d      = erro_q;
    // A sampled active flag retires the reservation; an allocation below is
    // applied afterwards so it wins over a same-cycle activation.
    reservado_d = reservado_q & ~na_ativo_i;
`ifdef GA_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          op_d        = req_op_i;
          endereco_d  = req_endereco_i;
          anterior_d  = req_anterior_i;
          custo_d     = req_custo_i;
          distancia_d = req_distancia_i;
          // Undefined ops are consumed without a response.
          if (req_op_i == OP_ATUALIZAR || req_op_i == OP_DESATIVAR) state_d = ST_BUSCA;
        end
      end
      ST_BUSCA, ST_ESPERA: begin
        if (hit_any) begin
          alvo_d  = hit_oh;
          erro_d  = hit_multi;
          miss_d  = 1'b0;
          state_d = ST_RESP;
        end else if (op_q == OP_DESATIVAR) begin
          alvo_d  = '0;
          erro_d  = 1'b0;
          miss_d  = 1'b1;
          state_d = ST_RESP;
        end else if (livre_any) begin
          alvo_d      = livre_oh;
          erro_d      = 1'b0;
          miss_d      = 1'b0;
          reservado_d = reservado_d | livre_oh;
          state_d     = ST_RESP;
        end else if (state_q == ST_BUSCA) begin
          state_d = ST_ESPERA;
`ifdef GA_TIMEOUT_EN
          tmo_d   = TMO_W'(TIMEOUT_CICLOS);
`endif
        end else begin
`ifdef GA_TIMEOUT_EN
          // The cycle that would bring the counter to zero ends the wait.
          if (tmo_q == TMO_W'(1)) begin
            alvo_d  = '0;
            erro_d  = 1'b0;
            miss_d  = 1'b1;
            state_d = ST_RESP;
          end else begin
            tmo_d = tmo_q - TMO_W'(1);
          end
`endif
        end
      end
      ST_RESP: begin
        if (op_q == OP_DESATIVAR) reservado_d = reservado_d & ~alvo_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      // NOTE: the reservation bitmap is reset as a whole; there is no
      // background clear, so a stale bit would hide a slot forever.
      reservado_q <= '0;
      op_q        <= '0;
      endereco_q  <= '0;
      anterior_q  <= '0;
      custo_q     <= '0;
      distancia_q <= '0;
      alvo_q      <= '0;
      miss_q      <= 1'b0;
      erro_q      <= 1'b0;
      livres_q    <= '0;
      cheio_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      reservado_q <= reservado_d;
      op_q        <= op_d;
      endereco_q  <= endereco_d;
      anterior_q  <= anterior_d;
      custo_q     <= custo_d;
      distancia_q <= distancia_d;
      alvo_q      <= alvo_d;
      miss_q      <= miss_d;
      erro_q      <= erro_d;
      livres_q    <= livres_d;
      cheio_q     <= cheio_d;
    end
  end

`ifdef GA_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  assign req_ready_o     = (state_q == ST_IDLE);
  assign rsp_valid_o     = (state_q == ST_RESP);
  assign rsp_habilitar_o = rsp_valid_o ? alvo_q : '0;
  assign rsp_miss_o      = rsp_valid_o & miss_q;
  assign rsp_erro_o      = rsp_valid_o & erro_q;
  assign rsp_op_o        = op_q;
  assign rsp_endereco_o  = endereco_q;
  assign rsp_anterior_o  = anterior_q;
  assign rsp_custo_o     = custo_q;
  assign rsp_distancia_o = distancia_q;
  assign livres_o        = livres_q;
  assign cheio_o         = cheio_q;

endmodule
